// File: rtl/apb_mem_slave.sv
// APB completer with a small byte-strobed word memory, optional wait states and
// error responses. Wait states exist only when APB_MEM_SLAVE_WAIT_EN is defined.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [1:0]              dbg_state
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(NB);
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NB - 1);

  if (!((DATA_WIDTH == 8) || (DATA_WIDTH == 16) || (DATA_WIDTH == 32)) ||
      (WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_param
    $error("apb_mem_slave: illegal DATA_WIDTH or WAIT_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Handshake: a transfer starts with one cycle of PSEL=1/PENABLE=0 and
  // completes in the ACCESS cycle where PREADY=1; PRDATA/PSLVERR are only
  // meaningful in that cycle, and dropping PSEL earlier abandons the transfer.
  state_t                  state_q, state_d, phase;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [IDX_W-1:0]        mem_idx;
  logic                    addr_err;
  logic                    ready;

  // A registered SETUP only means "a new setup may follow"; the cycle is a real
  // setup phase only when the bus shows PSEL=1/PENABLE=0, otherwise it is idle.
  always_comb begin
    if (state_q == ST_ACCESS) begin
      phase = ST_ACCESS;
    end else if (PSEL && !PENABLE) begin
      phase = ST_SETUP;
    end else begin
      phase = ST_IDLE;
    end
  end

  assign dbg_state = phase;
  assign word_idx  = addr_q >> OFF_BITS;
  assign mem_idx   = word_idx[IDX_W-1:0];
  assign addr_err  = ((addr_q & OFF_MASK) != '0) || (word_idx >= ADDR_WIDTH'(DEPTH));

`ifdef APB_MEM_SLAVE_WAIT_EN
  logic [3:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (phase == ST_SETUP) begin
      wait_d = 4'd0;
    end else if (phase == ST_ACCESS) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign ready = (phase == ST_ACCESS) && (wait_q == 4'(WAIT_CYCLES));
`else
  assign ready = (phase == ST_ACCESS);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (phase)
      ST_SETUP: begin
        state_d = ST_ACCESS;
        addr_d  = PADDR;
        write_d = PWRITE;
        wdata_d = PWDATA;
        strb_d  = PSTRB;
      end
      ST_ACCESS: begin
        if (ready) begin
          state_d = PSEL ? ST_SETUP : ST_IDLE;
        end else if (!PSEL) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (ready && write_q && !addr_err) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) begin
          mem_d[mem_idx][b*8 +: 8] = wdata_q[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && addr_err;
  assign PRDATA  = (ready && !write_q && !addr_err) ? mem_q[mem_idx] : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: timing, strobes, errors, protocol corner
// cases and reset; adapts expected ACCESS length to the APB_MEM_SLAVE_WAIT_EN build.
module tb_apb_mem_slave;

`ifdef APB_MEM_SLAVE_WAIT_EN
  localparam int EXP_ACC = 3;
  localparam int RST_AT  = 2;
`else
  localparam int EXP_ACC = 1;
  localparam int RST_AT  = 1;
`endif
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;

  logic        pclk, prst, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) dut (
    .PCLK(pclk), .PRESET(prst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr), .dbg_state(dbg_state)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One transfer; bus fields are scrambled during ACCESS to prove they were latched.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic keep_sel,
                          output logic [31:0] rdata, output logic slverr,
                          output int acc_cycles, output logic [1:0] setup_st);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(negedge pclk);
    setup_st = dbg_state;
    if (pready) setup_st = 2'd3;
    @(posedge pclk); #1;
    penable = 1'b1; pwrite = ~wr;
    paddr = 12'($urandom_range(0, 4095)); pwdata = $urandom; pstrb = 4'($urandom_range(0, 15));
    acc_cycles = 0; rdata = '0; slverr = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge pclk);
      if (pready) begin
        acc_cycles = i; rdata = prdata; slverr = pslverr;
        break;
      end
    end
    if (!keep_sel || acc_cycles == 0) begin
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic test_reset();
    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(negedge pclk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", pslverr); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h want 0", prdata); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    prst = 1'b0;
  endtask

  task automatic test_wait_timing();
    logic [31:0] rd; logic err; int n; logic [1:0] st;
    apb_xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 1'b0, rd, err, n, st);
    checks++; if (st !== S_SETUP) begin errors++; $display("FAIL timing_setup_state: got %0d want %0d", st, S_SETUP); end
    checks++; if (n != EXP_ACC) begin errors++; $display("FAIL timing_write_cycles: got %0d want %0d", n, EXP_ACC); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timing_write_err: got %b want 0", err); end
    @(negedge pclk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL timing_pulse: got %b want 0", pready); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL timing_idle: got %0d want %0d", dbg_state, S_IDLE); end
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (n != EXP_ACC) begin errors++; $display("FAIL timing_read_cycles: got %0d want %0d", n, EXP_ACC); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL timing_read_data: got %h want deadbeef", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timing_read_err: got %b want 0", err); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err; int n; logic [1:0] st;
    apb_xfer(1'b1, 12'h008, 32'h11223344, 4'hF, 1'b0, rd, err, n, st);
    apb_xfer(1'b1, 12'h008, 32'hAABBCCDD, 4'h5, 1'b0, rd, err, n, st);
    apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge: got %h want 11bb33dd", rd); end
    apb_xfer(1'b1, 12'h008, 32'hFFFFFFFF, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (err !== 1'b0 || n != EXP_ACC) begin errors++; $display("FAIL strobe_zero_resp: got err=%b cycles=%0d want err=0 cycles=%0d", err, n, EXP_ACC); end
    apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_zero_data: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int n; logic [1:0] st;
    apb_xfer(1'b0, 12'h040, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_range_read: got err=%b data=%h want err=1 data=0", err, rd); end
    apb_xfer(1'b1, 12'h041, 32'hFFFFFFFF, 4'hF, 1'b0, rd, err, n, st);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misaligned_041: got %b want 1", err); end
    apb_xfer(1'b1, 12'h005, 32'hFFFFFFFF, 4'hF, 1'b0, rd, err, n, st);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misaligned_005: got %b want 1", err); end
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (err !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_untouched: got err=%b data=%h want err=0 data=deadbeef", err, rd); end
    apb_xfer(1'b0, 12'h03C, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL err_last_word: got err=%b data=%h want err=0 data=0", err, rd); end
  endtask

  task automatic test_no_setup();
    logic [31:0] rd; logic err; int n; logic [1:0] st; logic seen;
    seen = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h0; pstrb = 4'hF;
    repeat (6) begin
      @(negedge pclk);
      if (pready) seen = 1'b1;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL nosetup_pready: got %b want 0", seen); end
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL nosetup_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_abort();
`ifdef APB_MEM_SLAVE_WAIT_EN
    logic [31:0] rd; logic err; int n; logic [1:0] st;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h55AA55AA; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL abort_early_pready: got %b want 0", pready); end
    psel = 1'b0; penable = 1'b0;
    repeat (4) @(negedge pclk);
    checks++; if (dbg_state !== S_IDLE || pready !== 1'b0) begin errors++; $display("FAIL abort_idle: got state=%0d pready=%b want state=0 pready=0", dbg_state, pready); end
    apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_no_write: got %h want 0", rd); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int n; logic [1:0] st;
    apb_xfer(1'b1, 12'h010, 32'hA1A1A1A1, 4'hF, 1'b1, rd, err, n, st);
    apb_xfer(1'b1, 12'h014, 32'hB2B2B2B2, 4'hF, 1'b0, rd, err, n, st);
    checks++; if (st !== S_SETUP) begin errors++; $display("FAIL b2b_second_setup: got %0d want %0d", st, S_SETUP); end
    checks++; if (n != EXP_ACC) begin errors++; $display("FAIL b2b_second_cycles: got %0d want %0d", n, EXP_ACC); end
    apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (rd !== 32'hA1A1A1A1) begin errors++; $display("FAIL b2b_word0: got %h want a1a1a1a1", rd); end
    apb_xfer(1'b0, 12'h014, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (rd !== 32'hB2B2B2B2) begin errors++; $display("FAIL b2b_word1: got %h want b2b2b2b2", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int n; logic [1:0] st;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (RST_AT) @(negedge pclk);
    prst = 1'b1;
    #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL rstmid_pready: got %b want 0", pready); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d want %0d", dbg_state, S_IDLE); end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    prst = 1'b0;
    apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (rd !== 32'h0 || n != EXP_ACC) begin errors++; $display("FAIL rstmid_read: got data=%h cycles=%0d want data=0 cycles=%0d", rd, n, EXP_ACC); end
    apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rd, err, n, st);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_cleared: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_wait_timing();
    test_strobes();
    test_errors();
    test_no_setup();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
